// File: rtl/ctrl_seq_pkg.sv
// Shared types for control_sequencer: FSM states, opcode constants and opcode classification.
// classify() treats opcode 0xE as a branch only when CTRL_BRANCH_EN is defined.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    HALTED  = 3'd3,
    STOPPED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_BRANCH  = 2'd1,
    CLS_HALT    = 2'd2,
    CLS_INVALID = 2'd3
  } op_class_t;

  localparam logic [3:0] OP_ALU_LAST = 4'h9;
  localparam logic [3:0] OP_BRANCH   = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  function automatic op_class_t classify(input logic [3:0] opcode);
    op_class_t cls;
    if (opcode <= OP_ALU_LAST) begin
      cls = CLS_ALU;
    end else if (opcode == OP_HALT) begin
      cls = CLS_HALT;
    end else if (opcode == OP_BRANCH) begin
`ifdef CTRL_BRANCH_EN
      cls = CLS_BRANCH;
`else
      cls = CLS_INVALID;
`endif
    end else begin
      cls = CLS_INVALID;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_pc_unit.sv
// Program counter for control_sequencer: reset load, wrapping increment and branch-target load.
module ctrl_pc_unit
  import ctrl_seq_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // A taken branch wins over the increment; the add wraps naturally at PC_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, the imem handshake, the instruction register
// and the exec_start/exec_done handshake. Define CTRL_BRANCH_EN to enable opcode 0xE branches.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int          INSTR_W  = 32,
  parameter int          PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               cond_flag,
  input  logic               resume,
  output logic [2:0]         state,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  state_t           state_q;
  op_class_t        op_class;
  logic             in_decode;
  logic             pc_inc;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic [CNT_W-1:0] retired_inc;

  assign op_class  = classify(instr[INSTR_W-1 -: 4]);
  assign in_decode = (state_q == DECODE);
  assign pc_target = instr[PC_W-1:0];

`ifdef CTRL_BRANCH_EN
  assign pc_load = in_decode && (op_class == CLS_BRANCH) && cond_flag;
`else
  logic unused_cond_flag;
  assign unused_cond_flag = cond_flag;
  assign pc_load          = 1'b0;
`endif

  // Every decoded instruction except an invalid one (or a taken branch) advances the PC.
  assign pc_inc = in_decode &&
                  ((op_class == CLS_ALU) || (op_class == CLS_HALT) ||
                   ((op_class == CLS_BRANCH) && !pc_load));

  assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

  ctrl_pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (pc_target),
    .pc     (imem_addr)
  );

  assign state = state_q;

  // exec_start doubles as the "first EXEC cycle" marker, so exec_done is only honoured after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      instr      <= '0;
      retired    <= '0;
      imem_req   <= 1'b0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      exec_start <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (imem_req && imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
            state_q  <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          unique case (op_class)
            CLS_ALU: begin
              exec_start <= 1'b1;
              state_q    <= EXEC;
            end
            CLS_HALT: begin
              retired <= retired_inc;
              halted  <= 1'b1;
              state_q <= HALTED;
            end
            CLS_BRANCH: begin
              retired  <= retired_inc;
              imem_req <= 1'b1;
              state_q  <= FETCH;
            end
            CLS_INVALID: begin
              fault   <= 1'b1;
              state_q <= STOPPED;
            end
          endcase
        end
        EXEC: begin
          if (!exec_start && exec_done) begin
            retired  <= retired_inc;
            imem_req <= 1'b1;
            state_q  <= FETCH;
          end
        end
        HALTED: begin
          if (resume) begin
            halted   <= 1'b0;
            imem_req <= 1'b1;
            state_q  <= FETCH;
          end
        end
        STOPPED: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          fault    <= 1'b1;
          state_q  <= STOPPED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized programs
// compared against an instruction-level interpreter of the program memory.
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ack, exec_start, exec_done, cond_flag, resume, halted, fault;
  logic [15:0] imem_addr, retired;
  logic [31:0] imem_data, instr;
  logic [2:0]  state;

  logic        s_rst, s_imem_req, s_exec_start, s_halted, s_fault;
  logic        s_imem_ack = 1'b1, s_exec_done = 1'b1, s_cond_flag = 1'b0, s_resume = 1'b0;
  logic [31:0] s_imem_data = 32'h1000_0000;
  logic [31:0] s_instr;
  logic [3:0]  s_imem_addr;
  logic [2:0]  s_state;
  logic [1:0]  s_retired;

  control_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .exec_start(exec_start), .exec_done(exec_done),
    .cond_flag(cond_flag), .resume(resume), .state(state), .halted(halted), .fault(fault),
    .retired(retired)
  );

  control_sequencer #(.INSTR_W(32), .PC_W(4), .RESET_PC(15), .CNT_W(2)) dut_small (
    .clk(clk), .rst(s_rst), .imem_addr(s_imem_addr), .imem_req(s_imem_req), .imem_ack(s_imem_ack),
    .imem_data(s_imem_data), .instr(s_instr), .exec_start(s_exec_start), .exec_done(s_exec_done),
    .cond_flag(s_cond_flag), .resume(s_resume), .state(s_state), .halted(s_halted),
    .fault(s_fault), .retired(s_retired)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] mem [256];
  int wait_left, done_left, mem_wait_max, exec_lat_min, exec_lat_max;
  int first_wait = -1;
  int cond_force = -1;
  bit exec_busy, noise, resume_force;
  logic [15:0] fetch_log[$];
  logic        cond_log[$];
  logic [31:0] exec_log[$];
  int          exec_cyc_log[$];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one cycle of memory/datapath/control inputs from the current outputs, then advances.
  task automatic step();
    if (imem_req) begin
      if (wait_left == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr[7:0]];
        cond_flag = (cond_force >= 0) ? 1'(cond_force) : 1'($urandom_range(0, 1));
        fetch_log.push_back(imem_addr);
        cond_log.push_back(cond_flag);
        wait_left = $urandom_range(0, mem_wait_max);
      end else begin
        imem_ack  = 1'b0;
        imem_data = $urandom;
        wait_left--;
      end
    end else begin
      imem_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_data = $urandom;
    end
    if (exec_start) begin
      exec_log.push_back(instr);
      exec_cyc_log.push_back(cyc);
      exec_busy = 1'b1;
      done_left = $urandom_range(exec_lat_min, exec_lat_max);
      exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end else if (exec_busy) begin
      done_left--;
      exec_done = (done_left == 0);
      if (done_left == 0) exec_busy = 1'b0;
    end else begin
      exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    resume = resume_force ? 1'b1 : ((noise && !halted) ? 1'($urandom_range(0, 1)) : 1'b0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) mem[a] = 32'hD000_0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; resume = 1'b0; cond_flag = 1'b0;
    imem_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    fetch_log.delete(); cond_log.delete(); exec_log.delete(); exec_cyc_log.delete();
    exec_busy = 1'b0; done_left = 0;
    wait_left = (first_wait >= 0) ? first_wait : $urandom_range(0, mem_wait_max);
    cyc = 0;
  endtask

  task automatic run_until_end(input int budget, input string name);
    int n = 0;
    while (!halted && !fault && n < budget) begin step(); n++; end
    checks++;
    if (!halted && !fault) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got no halt/fault, required one within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      imem_ack = 1'($urandom_range(0, 1)); exec_done = 1'($urandom_range(0, 1));
      resume = 1'($urandom_range(0, 1)); cond_flag = 1'($urandom_range(0, 1)); imem_data = $urandom;
      @(posedge clk); #1;
    end
    checks++;
    if ({state, imem_addr, imem_req, instr, exec_start, halted, fault, retired} !==
        {FETCH, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got st=%0d addr=%h req=%b ir=%h es=%b h=%b f=%b ret=%0d, required st=0 addr=0 rest 0",
               state, imem_addr, imem_req, instr, exec_start, halted, fault, retired);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_data = 32'h1000_0000;
    @(posedge clk); #1;
    checks++;
    if ({imem_req, state, instr} !== {1'b1, FETCH, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_first_req: got req=%b st=%0d ir=%h, required req=1 st=FETCH ir=0",
               imem_req, state, instr);
    end
  endtask

  task automatic test_program_halt();
    fill_mem();
    mem[0] = 32'h1000_0011; mem[1] = 32'h2000_0022; mem[2] = 32'hF000_0000; mem[3] = 32'h0000_0033;
    noise = 1'b0; mem_wait_max = 0; exec_lat_min = 1; exec_lat_max = 1;
    do_reset();
    run_until_end(60, "prog_halt");
    checks++;
    if (exec_cyc_log.size() != 2 || exec_cyc_log[0] != 3 || exec_cyc_log[1] != 7) begin
      errors++;
      $display("[TB] FAIL prog_exec_start_cycles: got n=%0d first=%0d, required 2 pulses at 3 and 7",
               exec_cyc_log.size(), (exec_cyc_log.size() > 0) ? exec_cyc_log[0] : -1);
    end
    checks++;
    if (cyc != 11 || halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prog_halt_cycle: got halted=%b at cycle %0d, required halted=1 first at cycle 11", halted, cyc);
    end
    checks++;
    if (retired !== 16'd3 || imem_addr !== 16'd3) begin
      errors++;
      $display("[TB] FAIL prog_retired_pc: got ret=%0d addr=%h, required ret=3 addr=3", retired, imem_addr);
    end
    checks++;
    if (exec_log.size() != 2 || exec_log[0] !== mem[0] || exec_log[1] !== mem[1]) begin
      errors++;
      $display("[TB] FAIL prog_exec_instr: got n=%0d, required instr 10000011 then 20000022", exec_log.size());
    end
  endtask

  task automatic test_resume();
    int n = 0;
    resume_force = 1'b1;
    step();
    resume_force = 1'b0;
    checks++;
    if ({halted, imem_req, imem_addr, state} !== {1'b0, 1'b1, 16'd3, FETCH}) begin
      errors++;
      $display("[TB] FAIL resume_fetch: got h=%b req=%b addr=%h st=%0d, required h=0 req=1 addr=3 st=FETCH",
               halted, imem_req, imem_addr, state);
    end
    while (exec_log.size() < 3 && n < 20) begin step(); n++; end
    checks++;
    if (exec_log.size() != 3 || exec_log[2] !== 32'h0000_0033) begin
      errors++;
      $display("[TB] FAIL resume_exec: got %0d exec pulses, required 3rd with instr 00000033", exec_log.size());
    end
  endtask

  task automatic test_invalid();
    fill_mem();
    mem[0] = 32'hB000_0000;
    noise = 1'b0;
    do_reset();
    run_until_end(20, "invalid");
    checks++;
    if ({fault, halted, imem_req, imem_addr, retired} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0} ||
        cyc != 3 || exec_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL invalid_fault: got f=%b h=%b req=%b addr=%h ret=%0d cyc=%0d starts=%0d, required f=1 at cycle 3, rest 0",
               fault, halted, imem_req, imem_addr, retired, cyc, exec_log.size());
    end
    resume_force = 1'b1;
    step();
    resume_force = 1'b0;
    repeat (3) step();
    checks++;
    if ({fault, halted, imem_req, state} !== {1'b1, 1'b0, 1'b0, STOPPED} || exec_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL invalid_sticky: got f=%b h=%b req=%b st=%0d, required f=1 h=0 req=0 st=STOPPED",
               fault, halted, imem_req, state);
    end
  endtask

  task automatic test_branch();
    for (int c = 1; c >= 0; c--) begin
      int n = 0;
      logic [15:0] exp_addr;
      fill_mem();
      mem[0] = 32'hE000_0040;
      noise = 1'b0; mem_wait_max = 0; cond_force = c;
      do_reset();
      while (n < 20 && !fault && !(fetch_log.size() == 1 && imem_req)) begin step(); n++; end
`ifdef CTRL_BRANCH_EN
      exp_addr = (c == 1) ? 16'h0040 : 16'h0001;
      checks++;
      if ({fault, imem_req, imem_addr, retired} !== {1'b0, 1'b1, exp_addr, 16'd1}) begin
        errors++;
        $display("[TB] FAIL branch_cond%0d: got f=%b req=%b addr=%h ret=%0d, required f=0 req=1 addr=%h ret=1",
                 c, fault, imem_req, imem_addr, retired, exp_addr);
      end
`else
      exp_addr = 16'h0000;
      checks++;
      if ({fault, imem_addr, retired} !== {1'b1, exp_addr, 16'd0}) begin
        errors++;
        $display("[TB] FAIL branch_disabled_cond%0d: got f=%b addr=%h ret=%0d, required f=1 addr=0 ret=0",
                 c, fault, imem_addr, retired);
      end
`endif
    end
    cond_force = -1;
  endtask

  task automatic test_stall_and_reset();
    int n = 0;
    fill_mem();
    mem[0] = 32'h3000_0001; mem[1] = 32'h4000_0002;
    noise = 1'b0; first_wait = 5; mem_wait_max = 0; exec_lat_min = 3; exec_lat_max = 3;
    do_reset();
    first_wait = -1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({imem_req, imem_addr, state, instr} !== {1'b1, 16'h0, FETCH, 32'h0}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got req=%b addr=%h st=%0d ir=%h, required req=1 addr=0 st=FETCH ir=0",
                 i, imem_req, imem_addr, state, instr);
      end
    end
    while (exec_log.size() < 2 && n < 60) begin step(); n++; end
    checks++;
    if (exec_log.size() != 2 || retired !== 16'd1 || imem_addr !== 16'd2 || state !== EXEC) begin
      errors++;
      $display("[TB] FAIL stall_second_exec: got starts=%0d ret=%0d addr=%h st=%0d, required 2, 1, 2, EXEC",
               exec_log.size(), retired, imem_addr, state);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({state, imem_addr, retired, exec_start, imem_req} !== {FETCH, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: got st=%0d addr=%h ret=%0d es=%b req=%b, required FETCH 0 0 0 0",
               state, imem_addr, retired, exec_start, imem_req);
    end
    rst = 1'b0;
    exec_busy = 1'b0;
    exec_lat_min = 1; exec_lat_max = 1;
  endtask

  task automatic test_wrap_saturate();
    logic [3:0] addrs[$];
    logic [3:0] exp_a;
    int starts = 0;
    int n = 0;
    int sat = (1 << 2) - 1;
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    checks++;
    if (s_imem_addr !== 4'hF || s_retired !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_reset_pc: got addr=%h ret=%0d, required addr=f ret=0", s_imem_addr, s_retired);
    end
    while (starts < 5 && n < 100) begin
      if (s_imem_req) addrs.push_back(s_imem_addr);
      if (s_exec_start) begin
        starts++;
        if (starts == 3) begin
          checks++;
          if (s_retired !== 2'd2) begin
            errors++;
            $display("[TB] FAIL wrap_retired_mid: got %0d, required 2", s_retired);
          end
        end
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (starts != 5 || int'(s_retired) != ((starts < sat) ? starts : sat)) begin
      errors++;
      $display("[TB] FAIL wrap_saturate: got starts=%0d ret=%0d, required starts=5 ret=3", starts, s_retired);
    end
    exp_a = 4'hF;
    checks++;
    if (addrs.size() != 5) begin
      errors++;
      $display("[TB] FAIL wrap_fetch_count: got %0d fetches, required 5", addrs.size());
    end
    for (int i = 0; i < addrs.size() && i < 5; i++) begin
      checks++;
      if (addrs[i] !== exp_a) begin
        errors++;
        $display("[TB] FAIL wrap_fetch_addr%0d: got %h, required %h", i, addrs[i], exp_a);
      end
      exp_a = exp_a + 4'd1;
    end
  endtask

  task automatic test_random_programs();
    logic [15:0] exp_fetch[$];
    logic [31:0] exp_exec[$];
    logic [15:0] pc;
    logic [31:0] w;
    int ret, n;
    bit exp_halt;
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(4, 12);
      fill_mem();
      for (int a = 0; a < n; a++) begin
        int r = $urandom_range(0, 15);
        if (r < 11)       mem[a] = {4'($urandom_range(0, 9)), 28'($urandom)};
        else if (r < 14)  mem[a] = {4'hE, 12'($urandom), 16'($urandom_range(a + 1, n))};
        else if (r == 14) mem[a] = {4'($urandom_range(10, 13)), 28'($urandom)};
        else              mem[a] = {4'($urandom_range(0, 9)), 28'($urandom)};
      end
      mem[n] = {4'hF, 28'($urandom)};
      noise = 1'b1; mem_wait_max = $urandom_range(0, 3);
      exec_lat_min = 1; exec_lat_max = $urandom_range(1, 4);
      do_reset();
      run_until_end(800, "random");

      // Instruction-level interpretation of the same program and condition stream.
      exp_fetch.delete(); exp_exec.delete();
      pc = 16'h0; ret = 0; exp_halt = 1'b0;
      for (int k = 0; k < 64; k++) begin
        exp_fetch.push_back(pc);
        w = mem[pc[7:0]];
        if (w[31:28] <= 4'h9) begin
          exp_exec.push_back(w); pc++; ret++;
        end else if (w[31:28] == 4'hF) begin
          pc++; ret++; exp_halt = 1'b1;
          break;
`ifdef CTRL_BRANCH_EN
        end else if (w[31:28] == 4'hE) begin
          pc = (k < cond_log.size() && cond_log[k]) ? w[15:0] : pc + 16'd1;
          ret++;
`endif
        end else begin
          break;
        end
      end

      checks++;
      if (fetch_log.size() != exp_fetch.size() || exec_log.size() != exp_exec.size()) begin
        errors++;
        $display("[TB] FAIL rand%0d_counts: got fetches=%0d execs=%0d, required %0d and %0d",
                 t, fetch_log.size(), exec_log.size(), exp_fetch.size(), exp_exec.size());
      end
      for (int i = 0; i < fetch_log.size() && i < exp_fetch.size(); i++) begin
        checks++;
        if (fetch_log[i] !== exp_fetch[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_fetch%0d: got addr %h, required %h", t, i, fetch_log[i], exp_fetch[i]);
        end
      end
      for (int i = 0; i < exec_log.size() && i < exp_exec.size(); i++) begin
        checks++;
        if (exec_log[i] !== exp_exec[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_exec%0d: got instr %h, required %h", t, i, exec_log[i], exp_exec[i]);
        end
      end
      checks++;
      if ({halted, fault, retired, imem_addr} !== {exp_halt, !exp_halt, 16'(ret), pc}) begin
        errors++;
        $display("[TB] FAIL rand%0d_final: got h=%b f=%b ret=%0d addr=%h, required h=%b f=%b ret=%0d addr=%h",
                 t, halted, fault, retired, imem_addr, exp_halt, !exp_halt, ret, pc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0; cond_flag = 1'b0; resume = 1'b0;
    noise = 1'b0; resume_force = 1'b0; exec_busy = 1'b0;
    mem_wait_max = 0; exec_lat_min = 1; exec_lat_max = 1; wait_left = 0; done_left = 0; cyc = 0;
    fill_mem();
    test_reset();
    test_program_halt();
    test_resume();
    test_invalid();
    test_branch();
    test_stall_and_reset();
    test_wrap_saturate();
    test_random_programs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
